// File: rtl/multi_pkg.sv
// multi_seq shared types: FSM state encoding and sizing helpers.
// Helpers give the fixed issue-to-valid latency and the step-counter width.
package multi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int MULTI_LAT(input int w);
    return w + 1;
  endfunction

  function automatic int MULTI_CNT_W(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/multi_cond_neg.sv
// Conditional two's-complement negator used for operand magnitudes
// and for the final product sign fix-up.
module multi_cond_neg #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/multi_seq.sv
// Sequential shift-add WIDTHxWIDTH multiplier, signed or unsigned per op.
// Optional overflow flag output enabled by defining MULTI_OVF_EN.
module multi_seq
  import multi_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] prodt,
  output logic               valid,
  output logic               busy
`ifdef MULTI_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int CW = MULTI_CNT_W(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] mcd_q;
  logic             neg_q;
  logic [PW-1:0]    prodt_q;
  logic             valid_q;
  logic             busy_q;

  logic             neg_a;
  logic             neg_b;
  logic             take;
  logic [WIDTH-1:0] mlier_mag;
  logic [WIDTH-1:0] mcand_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [PW-1:0]    prod_fix;

  assign neg_a = sgn & mlier[WIDTH-1];
  assign neg_b = sgn & mcand[WIDTH-1];
  assign take  = start & (state_q != RUN);

  multi_cond_neg #(.W(WIDTH)) u_neg_mlier (
    .neg_i (neg_a),
    .a_i   (mlier),
    .y_o   (mlier_mag)
  );

  multi_cond_neg #(.W(WIDTH)) u_neg_mcand (
    .neg_i (neg_b),
    .a_i   (mcand),
    .y_o   (mcand_mag)
  );

  assign sum  = {1'b0, hi_q}
              + {1'b0, mcd_q & {WIDTH{lo_q[0]}}};
  assign hi_d = sum[WIDTH:1];
  assign lo_d = {sum[0], lo_q[WIDTH-1:1]};

  multi_cond_neg #(.W(PW)) u_neg_prod (
    .neg_i (neg_q),
    .a_i   ({hi_d, lo_d}),
    .y_o   (prod_fix)
  );

`ifdef MULTI_OVF_EN
  logic          sgn_q;
  logic          ovf_q;
  logic          ovf_d;
  logic [WIDTH:0] top;

  assign top   = prod_fix[PW-1:WIDTH-1];
  assign ovf_d = sgn_q ? ~((&top) | (~|top))
                       : (|prod_fix[PW-1:WIDTH]);
  assign ovf   = ovf_q;
`endif

  // Issue from IDLE starts the counter at 0, spending one alignment
  // cycle; issue from DONE overlaps that cycle with the valid pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mcd_q   <= '0;
      neg_q   <= 1'b0;
      prodt_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MULTI_OVF_EN
      sgn_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (take) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        cnt_q   <= (state_q == DONE) ? CW'(1) : '0;
        hi_q    <= '0;
        lo_q    <= mlier_mag;
        mcd_q   <= mcand_mag;
        neg_q   <= neg_a ^ neg_b;
`ifdef MULTI_OVF_EN
        sgn_q   <= sgn;
`endif
      end else begin
        unique case (state_q)
          IDLE: ;
          RUN: begin
            if (cnt_q == '0) begin
              cnt_q <= CW'(1);
            end else begin
              hi_q <= hi_d;
              lo_q <= lo_d;
              if (cnt_q == CW'(WIDTH)) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                valid_q <= 1'b1;
                prodt_q <= prod_fix;
`ifdef MULTI_OVF_EN
                ovf_q   <= ovf_d;
`endif
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign prodt = prodt_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_multi_seq.sv
// Directed and random checks of multi_seq at WIDTH=32 and WIDTH=4.
// Covers latency, busy window, handshake corners, reset and ovf.
module tb_multi_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st32, sg32, v32, bz32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        st4, sg4, v4, bz4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
`ifdef MULTI_OVF_EN
  logic        o32, o4;
`endif

  int n_run  = 0;
  int n_fail = 0;

  multi_seq #(.WIDTH(32)) u32 (
    .clock (clk),
    .reset (rst),
    .start (st32),
    .sgn   (sg32),
    .mlier (a32),
    .mcand (b32),
    .prodt (p32),
    .valid (v32),
    .busy  (bz32)
`ifdef MULTI_OVF_EN
    ,
    .ovf   (o32)
`endif
  );

  multi_seq #(.WIDTH(4)) u4 (
    .clock (clk),
    .reset (rst),
    .start (st4),
    .sgn   (sg4),
    .mlier (a4),
    .mcand (b4),
    .prodt (p4),
    .valid (v4),
    .busy  (bz4)
`ifdef MULTI_OVF_EN
    ,
    .ovf   (o4)
`endif
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        o;
  } v32_t;

  typedef struct {
    logic       s;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       o;
  } v4_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // inj >= 0 pulses start with junk operands that many cycles into RUN
  task automatic op32(input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] ep,
                      input logic eo, input string nm, input int inj);
    int lat, bsy;
    @(negedge clk);
    sg32 = s; a32 = a; b32 = b; st32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0; a32 = ~a; b32 = ~b; sg32 = ~s;
    lat = 0; bsy = 0;
    while (!v32 && lat < 80) begin
      if (bz32) bsy++;
      st32 = (lat == inj);
      if (lat == inj) begin
        a32 = 32'd100; b32 = 32'd100;
      end
      lat++;
      @(negedge clk);
    end
    st32 = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " busy cycles"}, 64'(bsy), 64'd33);
    chk({nm, " prodt"}, p32, ep);
    chk({nm, " busy in done"}, {63'd0, bz32}, 64'd0);
`ifdef MULTI_OVF_EN
    chk({nm, " ovf"}, {63'd0, o32}, {63'd0, eo});
`else
    if (eo === 1'bx) chk({nm, " ovf x"}, 64'd0, 64'd1);
`endif
    @(negedge clk);
    chk({nm, " valid pulse"}, {63'd0, v32}, 64'd0);
    chk({nm, " prodt hold"}, p32, ep);
  endtask

  task automatic op4(input logic s, input logic [3:0] a,
                     input logic [3:0] b, input logic [7:0] ep,
                     input logic eo, input string nm);
    int lat, bsy;
    @(negedge clk);
    sg4 = s; a4 = a; b4 = b; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0; a4 = ~a; b4 = ~b;
    lat = 0; bsy = 0;
    while (!v4 && lat < 40) begin
      if (bz4) bsy++;
      lat++;
      @(negedge clk);
    end
    chk({nm, " latency"}, 64'(lat), 64'd5);
    chk({nm, " busy cycles"}, 64'(bsy), 64'd5);
    chk({nm, " prodt"}, {56'd0, p4}, {56'd0, ep});
`ifdef MULTI_OVF_EN
    chk({nm, " ovf"}, {63'd0, o4}, {63'd0, eo});
`else
    if (eo === 1'bx) chk({nm, " ovf x"}, 64'd0, 64'd1);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v32_t t32[9];
    v4_t  t4[6];
    int   nv, gap;
    t32[0] = '{1'b1, 32'd3, 32'd5, 64'd15, 1'b0};
    t32[1] = '{1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0};
    t32[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 1'b1};
    t32[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 1'b1};
    t32[4] = '{1'b0, 32'd3, 32'd5, 64'd15, 1'b0};
    t32[5] = '{1'b0, 32'd0, 32'd12345, 64'd0, 1'b0};
    t32[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0};
    t32[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000,
               64'hC000_0000_8000_0000, 1'b1};
    t32[8] = '{1'b0, 32'h8000_0000, 32'd2, 64'h1_0000_0000, 1'b1};
    t4[0] = '{1'b1, 4'h8, 4'h8, 8'h40, 1'b1};
    t4[1] = '{1'b1, 4'h7, 4'h8, 8'hC8, 1'b1};
    t4[2] = '{1'b0, 4'hF, 4'hF, 8'hE1, 1'b1};
    t4[3] = '{1'b1, 4'hF, 4'h1, 8'hFF, 1'b0};
    t4[4] = '{1'b0, 4'h3, 4'h2, 8'h06, 1'b0};
    t4[5] = '{1'b1, 4'h0, 4'h9, 8'h00, 1'b0};

    rst = 1'b1;
    st32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
    st4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    chk("reset prodt", p32, 64'd0);
    chk("reset valid", {63'd0, v32}, 64'd0);
    chk("reset busy", {63'd0, bz32}, 64'd0);
`ifdef MULTI_OVF_EN
    chk("reset ovf", {63'd0, o32}, 64'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      op32(t32[i].s, t32[i].a, t32[i].b, t32[i].p, t32[i].o,
           $sformatf("vec32[%0d]", i), -1);

    // start pulsed mid-RUN must be ignored
    op32(1'b1, 32'd3, 32'd5, 64'd15, 1'b0, "midrun start", 10);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (v32) nv++;
    end
    chk("midrun no extra valid", 64'(nv), 64'd0);

    // start held high: back-to-back results
    @(negedge clk);
    sg32 = 1'b0; a32 = 32'd2; b32 = 32'd3; st32 = 1'b1;
    gap = 0;
    @(negedge clk);
    while (!v32 && gap < 80) begin
      gap++;
      @(negedge clk);
    end
    chk("held first latency", 64'(gap), 64'd33);
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      @(negedge clk);
      gap = 1;
      while (!v32 && gap < 80) begin
        gap++;
        @(negedge clk);
      end
      chk($sformatf("held gap %0d", k), 64'(gap), 64'd33);
      chk($sformatf("held prodt %0d", k), p32, 64'd6);
    end
    st32 = 1'b0;
    repeat (3) @(negedge clk);
    chk("held stop busy", {63'd0, bz32}, 64'd0);

    // reset 10 cycles into RUN
    @(negedge clk);
    sg32 = 1'b1; a32 = 32'd9; b32 = 32'd9; st32 = 1'b1;
    @(negedge clk);
    st32 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst run prodt", p32, 64'd0);
    chk("rst run valid", {63'd0, v32}, 64'd0);
    chk("rst run busy", {63'd0, bz32}, 64'd0);
    rst = 1'b0;
    nv = 0;
    repeat (50) begin
      @(negedge clk);
      if (v32) nv++;
    end
    chk("rst run no valid", 64'(nv), 64'd0);
    op32(1'b1, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0,
         "after reset", -1);

    for (int i = 0; i < 6; i++)
      op4(t4[i].s, t4[i].a, t4[i].b, t4[i].p, t4[i].o,
          $sformatf("vec4[%0d]", i));

    // random operands against a reference model
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 10; i++) begin
        logic [31:0] ra, rb;
        logic [63:0] ep;
        logic        eo;
        longint      sp;
        ra = $urandom;
        rb = $urandom;
        if (m == 1) begin
          sp = longint'($signed(ra)) * longint'($signed(rb));
          ep = 64'(sp);
          eo = (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
        end else begin
          ep = {32'd0, ra} * {32'd0, rb};
          eo = (ep > 64'h0000_0000_FFFF_FFFF);
        end
        op32(m[0], ra, rb, ep, eo, $sformatf("rnd32 m%0d #%0d", m, i), -1);
      end
    end

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 10; i++) begin
        logic [3:0] ra, rb;
        int         sp;
        logic       eo;
        ra = 4'($urandom);
        rb = 4'($urandom);
        if (m == 1) begin
          sp = int'($signed(ra)) * int'($signed(rb));
          eo = (sp < -8) || (sp > 7);
        end else begin
          sp = int'(ra) * int'(rb);
          eo = (sp > 15);
        end
        op4(m[0], ra, rb, 8'(sp), eo, $sformatf("rnd4 m%0d #%0d", m, i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_seq.md
# multi_seq

Parametrised sequential shift-add multiplier, the successor to the fixed 32-bit `multi` unit. It computes a WIDTH×WIDTH → 2·WIDTH product in a fixed, data-independent number of cycles. A per-operation mode input selects signed (two's complement) or unsigned operands. It uses the same start/valid handshake as `multi` and adds a busy output so upstream logic can issue back-to-back operations.

## Interface
- WIDTH, 32: operand width in bits; legal range 2..64.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on rising edges while not busy.
- sgn  in  1  1 = signed operands, 0 = unsigned; captured with start.
- mlier  in  WIDTH  multiplier; captured with start.
- mcand  in  WIDTH  multiplicand; captured with start.
- prodt  out  2·WIDTH  product; held from valid until the next valid.
- valid  out  1  one-cycle pulse; prodt is correct in that cycle.
- busy  out  1  high while an operation is in progress.
- ovf  out  1  overflow flag; present only with MULTI_OVF_EN (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures mlier, mcand and sgn. In signed mode the operands are converted to magnitudes, and the result sign is recorded as the XOR of the operand MSBs.
  - Clears the accumulator and step counter, then moves to RUN.
- RUN:
  - One step per cycle: if the multiplier LSB is 1, add the WIDTH-bit magnitude into the upper half of the accumulator; then shift the {carry, acc, multiplier} register right by 1.
  - Runs exactly WIDTH steps, then moves to DONE.
- DONE:
  - prodt takes the accumulator, two's-complement negated if the recorded result sign is 1. valid=1 for this cycle.
  - If start=1 in DONE, new operands are captured and the block goes directly to RUN; otherwise it goes to IDLE.
- Arithmetic:
  - Magnitudes are WIDTH bits unsigned, so −2^(WIDTH−1) is handled exactly.
  - The full 2·WIDTH product always fits, so nothing is truncated.
- Zero operands follow the same path and latency as any other operands; there is no early termination.
- start while busy (RUN) is ignored. Inputs are not sampled outside IDLE or DONE.
- Reset at any time:
  - state=IDLE, prodt=0, valid=0, busy=0, ovf=0.
  - Any operation in flight is discarded and produces no valid.

## Timing
- Start accepted at edge T0 → busy=1 from T0 through T0+WIDTH → valid=1 in the cycle following edge T0+WIDTH+1, i.e. latency WIDTH+1 clocks. For WIDTH=32 this is 33 clocks, matching `multi`.
- busy=0 in the DONE cycle, so a start held high issues back-to-back operations with throughput one result per WIDTH+1 clocks.
- prodt changes only on the edge that raises valid.
- Output reset values: prodt=0, valid=0, busy=0, ovf=0.

## Configuration
- MULTI_OVF_EN defined:
  - Adds the ovf port, registered alongside prodt and valid at DONE.
  - Signed mode: ovf=1 when the product is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Unsigned mode: ovf=1 when prodt[2·WIDTH−1:WIDTH] ≠ 0.
- MULTI_OVF_EN undefined:
  - The ovf port and its logic are absent.
  - All other behaviour and timing are identical.

## Structure
- Package multi_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the MULTI_LAT(WIDTH) constant function, returning WIDTH+1;
  - the step-counter width function, $clog2(WIDTH+1).
- One sub-module, multi_cond_neg, parametrised by width: a conditional two's-complement negator. It is instanced for each operand-magnitude conversion and for the product sign fix-up.

## Test plan
All scenarios use WIDTH=32 unless stated.
- Signed, 3 × 5, start at T0 → valid exactly 33 clocks later, prodt=15, busy high for 33 cycles.
- Signed, −7 × 6 and 0x80000000 × 0x80000000 → prodt=−42 and prodt=0x4000000000000000 respectively.
- Unsigned, 0xFFFFFFFF × 0xFFFFFFFF → prodt=0xFFFFFFFE00000001. With MULTI_OVF_EN, ovf=1; 3 × 5 gives ovf=0.
- Start pulsed mid-RUN with new operands → ignored; the first result is unaffected and no extra valid is produced. Start held high continuously → valid every 33 clocks.
- Reset asserted 10 cycles into RUN → next cycle prodt=0, valid=0, busy=0, and no valid follows. A new start afterwards yields the correct product.
- WIDTH=4, signed −8 × −8 → prodt=64 after 5 clocks. 10 random-operand runs per mode are checked against a reference model.
